pc_update_unit: RTL and testbench
=================================

// Module: pc_update_unit
// PURPOSE
// - Parametrised successor to the single-cycle PC source selector: N-way next-PC select plus the PC register itself.
// - Adds conditional branch write, alignment checking, exception entry with EPC/cause capture and a two-state trap sequencer.
// - Sits between the ALU/memory datapath and instruction fetch; the control FSM drives sel/pc_write/pc_write_cond/exc_req.
// PARAMETERS
// - DATA_W      32        PC / source width
// - N_SRC       5         number of next-PC sources (>=2)
// - SEL_W       3         select width; must satisfy 2**SEL_W >= N_SRC
// - RESET_PC    32'h0     PC value after reset
// - EXC_BASE    32'hFD    exception vector base; vector = EXC_BASE + cause
// - EPC_OFFSET  4         subtracted from pc_out when EPC is captured
// PORTS
// - clk            in   1               rising-edge clock
// - reset          in   1               async, active-low
// - src_data       in   N_SRC*DATA_W    packed sources; source i = src_data[i*DATA_W +: DATA_W]
// - sel            in   SEL_W           source index
// - pc_write       in   1               unconditional PC write
// - pc_write_cond  in   1               conditional (branch) PC write
// - cond_zero      in   1               ALU zero flag
// - branch_ne      in   1               1: branch if !zero (bne); 0: branch if zero (beq)
// - exc_req        in   1               external exception request (overflow/opcode)
// - exc_cause_in   in   2               cause for exc_req: 0 = opcode, 1 = overflow
// - pc_out         out  DATA_W          current PC (registered)
// - epc_out        out  DATA_W          captured exception PC
// - cause_out      out  2               captured cause; 2 = misaligned target
// - exc_ack        out  1               one-cycle pulse: vector loaded into PC
// - exc_lost       out  1               sticky: exception arrived while in TRAP
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low.
// - Reset (reset = 0): pc_out = RESET_PC; epc_out = 0; cause_out = 0; exc_ack = 0; exc_lost = 0; state = RUN.
// - Candidate (combinational): source[sel] if sel < N_SRC, else 0.
// - taken = pc_write | (pc_write_cond & (cond_zero ^ branch_ne)).
// - misaligned = taken & (candidate[1:0] != 2'b00).
// - State RUN, priority high to low:
//   1. exc_req: epc <= pc_out - EPC_OFFSET (mod 2**DATA_W); cause <= exc_cause_in; PC unchanged; -> TRAP.
//   2. misaligned: epc <= candidate; cause <= 2; PC unchanged; -> TRAP.
//   3. taken: pc_out <= candidate on the same edge (1-cycle latency, no bypass).
//   4. otherwise: hold.
// - State TRAP (exactly one cycle):
//   - pc_out <= EXC_BASE + cause_out; exc_ack = 1 during this cycle; -> RUN.
//   - pc_write, pc_write_cond and sel are ignored.
//   - exc_req or misaligned here: request dropped, exc_lost <= 1, epc/cause untouched.
// - exc_lost clears only on reset.
// - exc_ack is a Moore output (state == TRAP), never asserted in RUN.
// - Wrap-around: all PC/EPC arithmetic is modulo 2**DATA_W, no saturation.
// - Reset asserted mid-TRAP: immediate return to reset values; no vector load, no exc_ack.
// - Simultaneous exc_req and misaligned: exc_req wins; misaligned is not recorded.
// STRUCTURE
// - Shared package pc_pkg:
//   - state enum {RUN, TRAP}.
//   - cause constants CAUSE_OPCODE = 0, CAUSE_OVF = 1, CAUSE_ALIGN = 2.
//   - default EXC_BASE and EPC_OFFSET.
// - One sub-module: pc_src_mux (parametrised N_SRC x DATA_W selector, out-of-range -> 0).
// - Remaining logic (PC/EPC/cause registers, sequencer) stays in this module.
// TESTING
// - Reset: hold reset=0 for 3 cycles, release -> pc_out=0, epc_out=0, exc_ack=0 and no change while pc_write=0.
// - Uncond: sel=1, src1=0x40, pc_write=1 for 1 cycle -> pc_out=0x40 on the next edge; sel=7 with pc_write -> pc_out=0.
// - Branch: pc_write_cond=1, cond_zero=1, branch_ne=0, src0=0x80 -> pc_out=0x80; same with branch_ne=1 -> PC holds.
// - Overflow: pc_out=0x100, exc_req=1, cause_in=1 -> epc=0xFC, cause=1; next cycle exc_ack=1 and pc_out=0xFE.
// - Misaligned: pc_write=1, target 0x42 -> PC holds, epc=0x42, cause=2, then pc_out=0xFF; exc_req in TRAP -> exc_lost=1.
// - Wrap and mid-trap reset: pc_out=0, exc_req -> epc=0xFFFFFFFC; reset asserted during TRAP -> pc_out=0, exc_ack=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC update unit: trap sequencer states,
// exception cause codes and default vector/EPC parameters.
package pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } pc_state_e;

  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
  localparam logic [1:0] CAUSE_OVF    = 2'd1;
  localparam logic [1:0] CAUSE_ALIGN  = 2'd2;

  localparam logic [31:0] DEFAULT_EXC_BASE   = 32'hFD;
  localparam logic [31:0] DEFAULT_EPC_OFFSET = 32'd4;

endpackage

// File: rtl/pc_src_mux.sv
// N-way next-PC source selector; indices past the last source yield zero so
// an unused select encoding can never pull in a stale datapath value.
module pc_src_mux #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 5,
  parameter int SEL_W  = 3
) (
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       candidate
);

  always_comb begin
    candidate = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        candidate = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/pc_update_unit.sv
// PC register with N-way next-PC select, conditional branch write, alignment
// checking and a one-cycle trap sequencer that captures EPC/cause.
module pc_update_unit
  import pc_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                N_SRC      = 5,
  parameter int                SEL_W      = 3,
  parameter logic [DATA_W-1:0] RESET_PC   = '0,
  parameter logic [DATA_W-1:0] EXC_BASE   = DATA_W'(DEFAULT_EXC_BASE),
  parameter logic [DATA_W-1:0] EPC_OFFSET = DATA_W'(DEFAULT_EPC_OFFSET)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    pc_write,
  input  logic                    pc_write_cond,
  input  logic                    cond_zero,
  input  logic                    branch_ne,
  input  logic                    exc_req,
  input  logic [1:0]              exc_cause_in,
  output logic [DATA_W-1:0]       pc_out,
  output logic [DATA_W-1:0]       epc_out,
  output logic [1:0]              cause_out,
  output logic                    exc_ack,
  output logic                    exc_lost
);

  pc_state_e         state_q, state_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] epc_q, epc_d;
  logic [1:0]        cause_q, cause_d;
  logic              lost_q, lost_d;

  logic [DATA_W-1:0] candidate;
  logic              taken;
  logic              misaligned;

  pc_src_mux #(
    .DATA_W (DATA_W),
    .N_SRC  (N_SRC),
    .SEL_W  (SEL_W)
  ) u_src_mux (
    .src_data  (src_data),
    .sel       (sel),
    .candidate (candidate)
  );

  assign taken      = pc_write | (pc_write_cond & (cond_zero ^ branch_ne));
  assign misaligned = taken & (candidate[1:0] != 2'b00);

  // Exceptions take precedence over a misaligned target; a fault seen while
  // the vector is being loaded cannot be serviced and is only flagged.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    lost_d  = lost_q;
    unique case (state_q)
      RUN: begin
        if (exc_req) begin
          epc_d   = pc_q - EPC_OFFSET;
          cause_d = exc_cause_in;
          state_d = TRAP;
        end else if (misaligned) begin
          epc_d   = candidate;
          cause_d = CAUSE_ALIGN;
          state_d = TRAP;
        end else if (taken) begin
          pc_d = candidate;
        end
      end
      TRAP: begin
        pc_d    = EXC_BASE + DATA_W'(cause_q);
        state_d = RUN;
        if (exc_req || misaligned) begin
          lost_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
      cause_q <= CAUSE_OPCODE;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      lost_q  <= lost_d;
    end
  end

  assign pc_out    = pc_q;
  assign epc_out   = epc_q;
  assign cause_out = cause_q;
  assign exc_ack   = (state_q == TRAP);
  assign exc_lost  = lost_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: a behavioural model checked every
// cycle plus directed vectors with hand-computed literal expectations.
module tb_pc_update_unit;

  localparam int DATA_W = 32;
  localparam int N_SRC  = 5;
  localparam int SEL_W  = 3;

  logic                    clk;
  logic                    reset;
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [SEL_W-1:0]        sel;
  logic                    pc_write;
  logic                    pc_write_cond;
  logic                    cond_zero;
  logic                    branch_ne;
  logic                    exc_req;
  logic [1:0]              exc_cause_in;
  logic [DATA_W-1:0]       pc_out;
  logic [DATA_W-1:0]       epc_out;
  logic [1:0]              cause_out;
  logic                    exc_ack;
  logic                    exc_lost;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  logic [31:0] src [N_SRC];

  // Model state
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  bit          m_lost, m_trap;

  pc_update_unit dut (
    .clk           (clk),
    .reset         (reset),
    .src_data      (src_data),
    .sel           (sel),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .cond_zero     (cond_zero),
    .branch_ne     (branch_ne),
    .exc_req       (exc_req),
    .exc_cause_in  (exc_cause_in),
    .pc_out        (pc_out),
    .epc_out       (epc_out),
    .cause_out     (cause_out),
    .exc_ack       (exc_ack),
    .exc_lost      (exc_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written directly from the architectural rules.
  always @(posedge clk or negedge reset) begin
    logic [31:0] cand;
    bit take, mis;
    if (!reset) begin
      m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'd0; m_lost = 0; m_trap = 0;
    end else begin
      cand = (sel < N_SRC) ? src[sel] : 32'h0;
      take = pc_write || (pc_write_cond && (cond_zero != branch_ne));
      mis  = take && (cand % 4 != 0);
      if (m_trap) begin
        if (exc_req || mis) m_lost = 1;
        m_pc   = 32'hFD + 32'(m_cause);
        m_trap = 0;
      end else if (exc_req) begin
        m_epc = m_pc - 32'd4; m_cause = exc_cause_in; m_trap = 1;
      end else if (mis) begin
        m_epc = cand; m_cause = 2'd2; m_trap = 1;
      end else if (take) begin
        m_pc = cand;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check_output("model_pc",    pc_out,           m_pc);
      check_output("model_epc",   epc_out,          m_epc);
      check_output("model_cause", 32'(cause_out),   32'(m_cause));
      check_output("model_ack",   32'(exc_ack),     32'(m_trap));
      check_output("model_lost",  32'(exc_lost),    32'(m_lost));
    end
  end

  // Inputs are changed just after a falling edge, then one rising edge is taken.
  task automatic apply_stimulus(input logic [2:0] s, input logic pw, input logic pwc,
                                input logic cz, input logic bne, input logic er,
                                input logic [1:0] ec);
    sel = s; pc_write = pw; pc_write_cond = pwc; cond_zero = cz;
    branch_ne = bne; exc_req = er; exc_cause_in = ec;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    src[0] = 32'h80; src[1] = 32'h40; src[2] = 32'h42; src[3] = 32'h100; src[4] = 32'h0;
    src_data = {src[4], src[3], src[2], src[1], src[0]};
    reset = 1'b0;
    sel = '0; pc_write = 0; pc_write_cond = 0; cond_zero = 0; branch_ne = 0;
    exc_req = 0; exc_cause_in = 2'd0;

    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    reset  = 1'b1;
    check_output("reset_pc",  pc_out,        32'h0);
    check_output("reset_epc", epc_out,       32'h0);
    check_output("reset_ack", 32'(exc_ack),  32'h0);

    apply_stimulus(3'd1, 0, 0, 0, 0, 0, 2'd0);
    check_output("idle_hold_pc", pc_out, 32'h0);

    apply_stimulus(3'd1, 1, 0, 0, 0, 0, 2'd0);
    check_output("uncond_pc", pc_out, 32'h40);
    apply_stimulus(3'd7, 1, 0, 0, 0, 0, 2'd0);
    check_output("sel_oob_pc", pc_out, 32'h0);

    apply_stimulus(3'd0, 0, 1, 1, 0, 0, 2'd0);
    check_output("beq_taken_pc", pc_out, 32'h80);
    apply_stimulus(3'd1, 0, 1, 1, 1, 0, 2'd0);
    check_output("bne_not_taken_pc", pc_out, 32'h80);

    apply_stimulus(3'd3, 1, 0, 0, 0, 0, 2'd0);
    check_output("load_0x100", pc_out, 32'h100);
    apply_stimulus(3'd0, 0, 0, 0, 0, 1, 2'd1);
    check_output("ovf_epc",   epc_out,          32'hFC);
    check_output("ovf_cause", 32'(cause_out),   32'h1);
    check_output("ovf_pc",    pc_out,           32'h100);
    check_output("ovf_ack",   32'(exc_ack),     32'h1);
    apply_stimulus(3'd0, 0, 0, 0, 0, 0, 2'd0);
    check_output("ovf_vector", pc_out,       32'hFE);
    check_output("ovf_ack_end", 32'(exc_ack), 32'h0);

    apply_stimulus(3'd2, 1, 0, 0, 0, 0, 2'd0);
    check_output("align_pc",    pc_out,         32'hFE);
    check_output("align_epc",   epc_out,        32'h42);
    check_output("align_cause", 32'(cause_out), 32'h2);
    apply_stimulus(3'd0, 0, 0, 0, 0, 1, 2'd0);
    check_output("align_vector", pc_out,        32'hFF);
    check_output("lost_set",     32'(exc_lost), 32'h1);
    check_output("lost_epc",     epc_out,       32'h42);
    apply_stimulus(3'd0, 0, 0, 0, 0, 0, 2'd0);
    check_output("lost_sticky",  32'(exc_lost), 32'h1);

    apply_stimulus(3'd4, 1, 0, 0, 0, 0, 2'd0);
    check_output("load_zero", pc_out, 32'h0);
    apply_stimulus(3'd0, 0, 0, 0, 0, 1, 2'd0);
    check_output("wrap_epc", epc_out, 32'hFFFFFFFC);
    check_output("wrap_ack", 32'(exc_ack), 32'h1);

    #2 reset = 1'b0;
    #1;
    check_output("midtrap_pc",   pc_out,        32'h0);
    check_output("midtrap_ack",  32'(exc_ack),  32'h0);
    check_output("midtrap_lost", 32'(exc_lost), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    apply_stimulus(3'd0, 0, 0, 0, 0, 0, 2'd0);
    check_output("post_reset_pc", pc_out, 32'h0);

    apply_stimulus(3'd2, 1, 0, 0, 0, 1, 2'd1);
    check_output("prio_epc",   epc_out,        32'hFFFFFFFC);
    check_output("prio_cause", 32'(cause_out), 32'h1);
    apply_stimulus(3'd0, 0, 0, 0, 0, 0, 2'd0);
    check_output("prio_vector", pc_out, 32'hFE);
    check_output("prio_no_lost", 32'(exc_lost), 32'h0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
